// File: rtl/rca_writeback_sequencer.sv
// rca_writeback_sequencer
// Takes one RCA result bundle and drains it onto the single register-file
// writeback port, one destination register per cycle, lowest port first.
// Destination rds are snapshotted at accept time so config writes that land
// while a bundle is draining cannot redirect its remaining writes.
module rca_writeback_sequencer #(
    parameter int NUM_RCAS        = 4,
    parameter int NUM_WRITE_PORTS = 5,
    parameter int XLEN            = 32,
    parameter int ID_W            = 3,
    localparam int RCA_W = (NUM_RCAS > 1) ? $clog2(NUM_RCAS) : 1
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              res_valid,
    output logic                              res_ready,
    input  logic [RCA_W-1:0]                  res_rca_id,
    input  logic [ID_W-1:0]                   res_id,
    input  logic [NUM_WRITE_PORTS-1:0]        res_mask,
    input  logic [NUM_WRITE_PORTS*XLEN-1:0]   res_data,
    input  logic [NUM_RCAS*NUM_WRITE_PORTS*5-1:0] dst_map,
    input  logic [NUM_RCAS*NUM_WRITE_PORTS-1:0]   dst_en,
    output logic                              wb_valid,
    input  logic                              wb_ready,
    output logic [4:0]                        wb_rd,
    output logic [XLEN-1:0]                   wb_data,
    output logic [ID_W-1:0]                   wb_id,
    output logic                              wb_last,
    output logic                              done,
    output logic                              busy
);

    localparam int NWP = NUM_WRITE_PORTS;

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] WRITE = 1'b1;

    // Isolate the lowest set bit of a pending vector.
    function automatic logic [NWP-1:0] lowest_onehot(input logic [NWP-1:0] v);
        return v & ~(v - NWP'(1));
    endfunction

    // True when exactly one bit of a pending vector is set.
    function automatic logic single_bit(input logic [NWP-1:0] v);
        return (v != '0) && ((v & (v - NWP'(1))) == '0);
    endfunction

    logic [0:0]       state_r, state_nxt_s;
    logic [NWP-1:0]   pend_r, pend_nxt_s, new_pend_s, sel_s;
    logic [XLEN-1:0]  data_r     [NWP];
    logic [XLEN-1:0]  data_nxt_s [NWP];
    logic [4:0]       rd_r       [NWP];
    logic [4:0]       rd_nxt_s   [NWP];
    logic [4:0]       rd_row_s   [NWP];
    logic [NWP-1:0]   en_row_s;
    logic [ID_W-1:0]  id_r, id_nxt_s;
    logic             accept_s, fire_s, done_nxt_s;
    logic             wb_valid_r, wb_last_r, done_r;
    logic [4:0]       wb_rd_r, wb_rd_nxt_s;
    logic [XLEN-1:0]  wb_data_r, wb_data_nxt_s;
    logic [ID_W-1:0]  wb_id_r;

    assign res_ready = (state_r == IDLE);
    assign busy      = (state_r != IDLE);
    assign wb_valid  = wb_valid_r;
    assign wb_rd     = wb_rd_r;
    assign wb_data   = wb_data_r;
    assign wb_id     = wb_id_r;
    assign wb_last   = wb_last_r;
    assign done      = done_r;

    // Pick the config row of the producing RCA; an id with no row yields all-zero.
    always_comb begin
        en_row_s = '0;
        for (int p = 0; p < NWP; p++) begin
            rd_row_s[p] = 5'd0;
        end
        for (int r = 0; r < NUM_RCAS; r++) begin
            en_row_s = en_row_s |
                ((res_rca_id == RCA_W'(r)) ? dst_en[r*NWP +: NWP] : '0);
            for (int p = 0; p < NWP; p++) begin
                rd_row_s[p] = rd_row_s[p] |
                    ((res_rca_id == RCA_W'(r)) ? dst_map[(r*NWP+p)*5 +: 5] : 5'd0);
            end
        end
    end

    // Next-state, snapshot loading and next-cycle writeback output selection.
    always_comb begin
        accept_s    = res_valid && (state_r == IDLE);
        fire_s      = wb_valid_r && wb_ready;
        state_nxt_s = state_r;
        pend_nxt_s  = pend_r;
        done_nxt_s  = 1'b0;
        id_nxt_s    = accept_s ? res_id : id_r;
        for (int p = 0; p < NWP; p++) begin
            new_pend_s[p] = res_mask[p] && en_row_s[p] && (rd_row_s[p] != 5'd0);
            if (accept_s) begin
                data_nxt_s[p] = res_data[p*XLEN +: XLEN];
                rd_nxt_s[p]   = rd_row_s[p];
            end else begin
                data_nxt_s[p] = data_r[p];
                rd_nxt_s[p]   = rd_r[p];
            end
        end

        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    pend_nxt_s  = new_pend_s;
                    state_nxt_s = (new_pend_s != '0) ? WRITE : IDLE;
                    done_nxt_s  = (new_pend_s == '0);
                end else begin
                    pend_nxt_s  = '0;
                end
            end
            WRITE: begin
                if (fire_s) begin
                    pend_nxt_s = pend_r & (pend_r - NWP'(1));
                    if (pend_nxt_s == '0) begin
                        state_nxt_s = IDLE;
                        done_nxt_s  = 1'b1;
                    end else begin
                        state_nxt_s = WRITE;
                    end
                end else begin
                    pend_nxt_s = pend_r;
                end
            end
            default: begin
                state_nxt_s = IDLE;
                pend_nxt_s  = '0;
            end
        endcase

        sel_s         = lowest_onehot(pend_nxt_s);
        wb_rd_nxt_s   = 5'd0;
        wb_data_nxt_s = '0;
        for (int p = 0; p < NWP; p++) begin
            wb_rd_nxt_s   = wb_rd_nxt_s   | (sel_s[p] ? rd_nxt_s[p]   : 5'd0);
            wb_data_nxt_s = wb_data_nxt_s | (sel_s[p] ? data_nxt_s[p] : '0);
        end
    end

    // State, snapshot and registered writeback outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= IDLE;
            pend_r     <= '0;
            id_r       <= '0;
            wb_valid_r <= 1'b0;
            wb_rd_r    <= 5'd0;
            wb_data_r  <= '0;
            wb_id_r    <= '0;
            wb_last_r  <= 1'b0;
            done_r     <= 1'b0;
            for (int p = 0; p < NWP; p++) begin
                data_r[p] <= '0;
                rd_r[p]   <= 5'd0;
            end
        end else begin
            state_r    <= state_nxt_s;
            pend_r     <= pend_nxt_s;
            id_r       <= id_nxt_s;
            wb_valid_r <= (pend_nxt_s != '0);
            wb_rd_r    <= wb_rd_nxt_s;
            wb_data_r  <= wb_data_nxt_s;
            wb_id_r    <= (pend_nxt_s != '0) ? id_nxt_s : '0;
            wb_last_r  <= single_bit(pend_nxt_s);
            done_r     <= done_nxt_s;
            for (int p = 0; p < NWP; p++) begin
                data_r[p] <= data_nxt_s[p];
                rd_r[p]   <= rd_nxt_s[p];
            end
        end
    end

endmodule

// File: doc/rca_writeback_sequencer.md
Name: rca_writeback_sequencer

Overview:
- Return path for RCA use instructions. Accepts one RCA result bundle (up to NUM_WRITE_PORTS values) and serialises it onto the single register-file writeback port, one register per cycle.
- Destination registers come from the RCA config table written by config instructions: per RCA, per destination port, a 5-bit rd plus a port-enable bit.
- Sits between the RCA result mux and the writeback arbiter.

Parameters:
- NUM_RCAS, 4, number of RCAs; RCA_W = clog2(NUM_RCAS).
- NUM_WRITE_PORTS, 5, destination ports per RCA; PORT_W = clog2(NUM_WRITE_PORTS).
- XLEN, 32, data width.
- ID_W, 3, instruction id width.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- res_valid  in  1  result bundle valid.
- res_ready  out  1  sequencer can accept a bundle.
- res_rca_id  in  RCA_W  RCA that produced the bundle.
- res_id  in  ID_W  instruction id of the use instruction.
- res_mask  in  NUM_WRITE_PORTS  ports with a result.
- res_data  in  NUM_WRITE_PORTS*XLEN  port p at bits [p*XLEN +: XLEN].
- dst_map  in  NUM_RCAS*NUM_WRITE_PORTS*5  rd for (rca r, port p) at index (r*NUM_WRITE_PORTS+p)*5.
- dst_en  in  NUM_RCAS*NUM_WRITE_PORTS  destination port configured, index r*NUM_WRITE_PORTS+p.
- wb_valid  out  1  writeback request.
- wb_ready  in  1  writeback accepted.
- wb_rd  out  5  destination register.
- wb_data  out  XLEN  write data.
- wb_id  out  ID_W  instruction id.
- wb_last  out  1  final write of the bundle.
- done  out  1  one-cycle pulse: bundle fully retired.
- busy  out  1  state != IDLE.

Behaviour:
- Clock and reset: one clock `clk`; asynchronous active-low reset `rst_n`.
- Reset values: state IDLE; wb_valid, wb_last, done, busy = 0; wb_rd, wb_data, wb_id = 0; res_ready = 1 once rst_n is high.
- States: IDLE, WRITE.
- IDLE: res_ready = 1.
  - A bundle is accepted on res_valid & res_ready.
  - On accept, latch res_id and res_data.
  - Snapshot the rca's dst_map row into local registers, so config writes mid-bundle have no effect.
  - Compute pending = res_mask & dst_en row & (rd != 0 per port). Port-to-x0 writes are discarded.
- Accept with pending == 0: stay IDLE; done = 1 next cycle; no wb_valid.
- Accept with pending != 0: go to WRITE; wb_valid = 1 the next cycle (latency 1).
- WRITE: present the lowest-index set bit p of pending.
  - wb_rd = snapshot rd[p]; wb_data = data[p]; wb_id = latched id.
  - wb_last = 1 iff p is the only set bit.
- Handshake rules:
  - Outputs are held stable while wb_valid & !wb_ready.
  - On wb_valid & wb_ready: clear bit p; the next port is presented the following cycle, giving back-to-back writes with no bubble.
- Last handshake: go to IDLE; done = 1 in the following cycle; res_ready = 1 in that same cycle. A new bundle may be accepted then.
- res_ready = 0 throughout WRITE. No accept occurs in the cycle of the final handshake.
- Duplicate rd across ports: both writes are issued in ascending port order, so the higher port's value lands last.
- res_rca_id >= NUM_RCAS: treated as pending = 0 (done pulse, no writes).
- Reset mid-WRITE: pending writes dropped, no done, outputs return to reset values immediately.

Test Plan:
- Reset then idle: rst_n low for 3 cycles, then high -> res_ready = 1; wb_valid = 0 and done = 0 for 10 cycles.
- rca 1, mask 5'b10101, all enabled, rd map {p0:5, p2:7, p4:9}, wb_ready held 1 -> writes (5,d0), (7,d2), (9,d4) on 3 consecutive cycles starting 1 cycle after accept; wb_last on the 3rd write; done 1 cycle later.
- Backpressure: same bundle, wb_ready low for 4 cycles on the first write -> wb_rd = 5 and wb_data = d0 stable; order unchanged; res_ready = 0 throughout.
- Filtering: mask 5'b11111, dst_en row 5'b01111, port1 rd = 0 -> writes only ports 0, 2, 3. Separately, mask = 0 -> done one cycle after accept, no wb_valid.
- Config change mid-bundle: change dst_map for the active rca after accept -> writes use the old rd values. Duplicate rd = 3 on ports 0 and 1 -> two writes to x3, port1 data second.
- Reset mid-WRITE: rst_n low after the first of 3 writes -> wb_valid drops asynchronously, no done. After release, a fresh bundle is processed normally.
